// File: rtl/outer_acc_pkg.sv
// Shared constants and state encoding for the outer-product accumulator.
// Element count, index width and the two-state drain FSM encoding.
package outer_acc_pkg;
  localparam int N_ELEM = 9;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/outer_product_accumulator_lane.sv
// One accumulator lane: adds a zero-extended product on add_en, clears on clr.
// carry is a combinational pulse flagging wrap-around of this cycle's add.
module acc_lane #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             add_en,
  input  logic             clr,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] q,
  output logic             carry
);
  logic [ACC_W-1:0] r_q;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_q} + {{(ACC_W + 1 - IN_W){1'b0}}, din};
  assign carry = add_en & w_sum[ACC_W];
  assign q     = r_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (add_en) begin
      r_q <= w_sum[ACC_W-1:0];
    end
  end
endmodule

// File: rtl/outer_product_accumulator.sv
// Sums K outer-product beats element-wise into nine lanes, then streams the
// nine sums out on a valid/ready port and clears for the next matrix.
module outer_product_accumulator
  import outer_acc_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [IN_W-1:0]  c1,
  input  logic [IN_W-1:0]  c2,
  input  logic [IN_W-1:0]  c3,
  input  logic [IN_W-1:0]  c4,
  input  logic [IN_W-1:0]  c5,
  input  logic [IN_W-1:0]  c6,
  input  logic [IN_W-1:0]  c7,
  input  logic [IN_W-1:0]  c8,
  input  logic [IN_W-1:0]  c9,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf
);
  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_term_cnt;
  logic               r_ovf;
  logic               w_accept, w_fire, w_done, w_cnt_full;
  logic [IN_W-1:0]    w_c [N_ELEM];
  logic [ACC_W-1:0]   w_q [N_ELEM];
  logic [N_ELEM-1:0]  w_carry;
  logic [ACC_W-1:0]   w_data;

  assign w_c[0] = c1;
  assign w_c[1] = c2;
  assign w_c[2] = c3;
  assign w_c[3] = c4;
  assign w_c[4] = c5;
  assign w_c[5] = c6;
  assign w_c[6] = c7;
  assign w_c[7] = c8;
  assign w_c[8] = c9;

  assign in_ready   = (r_state == ST_ACCUM);
  assign out_valid  = (r_state == ST_DRAIN);
  assign w_accept   = in_valid & in_ready;
  assign w_fire     = out_valid & out_ready;
  assign w_done     = w_fire & (r_idx == LAST_IDX);
  assign w_cnt_full = &r_term_cnt;

  for (genvar g = 0; g < N_ELEM; g++) begin : g_lane
    acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .add_en (w_accept),
      .clr    (w_done),
      .din    (w_c[g]),
      .q      (w_q[g]),
      .carry  (w_carry[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && in_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_done) w_state_nxt = ST_ACCUM;
      default:  w_state_nxt = ST_ACCUM;
    endcase
  end

  // Output mux; held at zero outside DRAIN so partial sums never leak out.
  always_comb begin
    w_data = '0;
    if (out_valid) begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (r_idx == IDX_W'(i)) w_data = w_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ACCUM;
      r_idx      <= '0;
      r_term_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) begin
        r_idx      <= '0;
        r_term_cnt <= '0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_fire) r_idx <= r_idx + 1'b1;
        if (w_accept) begin
          if (!w_cnt_full) r_term_cnt <= r_term_cnt + 1'b1;
          if (w_cnt_full || (|w_carry)) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign out_data = w_data;
  assign out_idx  = r_idx;
  assign out_last = out_valid & (r_idx == LAST_IDX);
  assign term_cnt = r_term_cnt;
  assign ovf      = r_ovf;
endmodule

// File: tb/tb_outer_product_accumulator.sv
// Directed bench for outer_product_accumulator: scoreboard of expected sums
// against a default-width instance, plus a 17-bit instance for wrap-around.
module tb_outer_product_accumulator;
  localparam int IN_W = 17;
  localparam int ACC_W = 24;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last, ovf;
  logic [IN_W-1:0] c [9];
  logic [ACC_W-1:0] out_data;
  logic [3:0] out_idx;
  logic [CNT_W-1:0] term_cnt;

  logic s_valid, s_ready, s_last, s_out_valid, s_out_ready, s_out_last, s_ovf;
  logic [IN_W-1:0] s_c;
  logic [16:0] s_data;
  logic [3:0] s_idx;
  logic [CNT_W-1:0] s_cnt;

  outer_product_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .c1(c[0]), .c2(c[1]), .c3(c[2]), .c4(c[3]), .c5(c[4]), .c6(c[5]), .c7(c[6]), .c8(c[7]), .c9(c[8]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .term_cnt(term_cnt), .ovf(ovf)
  );

  outer_product_accumulator #(.IN_W(IN_W), .ACC_W(17), .CNT_W(CNT_W)) dut17 (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ready), .in_last(s_last),
    .c1(s_c), .c2(s_c), .c3(s_c), .c4(s_c), .c5(s_c), .c6(s_c), .c7(s_c), .c8(s_c), .c9(s_c),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_data), .out_idx(s_idx),
    .out_last(s_out_last), .term_cnt(s_cnt), .ovf(s_ovf)
  );

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [3:0]       idx;
    logic             last;
  } exp_t;

  exp_t q_exp[$];
  int checks = 0;
  int errors = 0;
  int m_acc[9];
  int m_cnt = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_outer(input int a1, input int a2, input int a3,
                           input int b1, input int b2, input int b3);
    int a[3];
    int b[3];
    a = '{a1, a2, a3};
    b = '{b1, b2, b3};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        c[3*i+j] = IN_W'(a[i] * b[j]);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 9; i++) c[i] = IN_W'(v);
  endtask

  // Reference model: element-wise sum; on the last beat queue the nine results.
  task automatic model_add(input bit last);
    exp_t e;
    for (int i = 0; i < 9; i++) m_acc[i] += int'(c[i]);
    m_cnt++;
    if (last) begin
      for (int i = 0; i < 9; i++) begin
        e.data = ACC_W'(m_acc[i]);
        e.idx  = 4'(i);
        e.last = (i == 8);
        q_exp.push_back(e);
        m_acc[i] = 0;
      end
      exp_cnt = m_cnt;
      m_cnt = 0;
    end
  endtask

  task automatic send(input bit last);
    int w;
    in_valid = 1'b1;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) chk("send_timeout", 32'd0, 32'd1);
    model_add(last);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input bit toggle, output int cycles);
    exp_t e;
    logic [ACC_W-1:0] pd;
    logic [3:0] pi;
    bit stalled;
    int cyc;
    cyc = 0;
    stalled = 0;
    pd = '0;
    pi = '0;
    while (q_exp.size() > 0 && cyc < 100) begin
      out_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
      #1;
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'd1);
      chk("drain_term_cnt", 32'(term_cnt), 32'(exp_cnt));
      chk("drain_ovf", 32'(ovf), 32'd0);
      if (stalled) begin
        chk("stall_data", 32'(out_data), 32'(pd));
        chk("stall_idx", 32'(out_idx), 32'(pi));
      end
      if (out_ready) begin
        e = q_exp.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.last));
        stalled = 0;
      end else begin
        chk("stall_no_last_pop", 32'(out_valid), 32'd1);
        stalled = 1;
        pd = out_data;
        pi = out_idx;
      end
      step();
      cyc++;
    end
    if (cyc >= 100) chk("drain_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    cycles = cyc;
  endtask

  task automatic drain17(input int expv, input bit expovf);
    for (int i = 0; i < 9; i++) begin
      chk("w17_valid", 32'(s_out_valid), 32'd1);
      chk("w17_data", 32'(s_data), 32'(expv));
      chk("w17_idx", 32'(s_idx), 32'(i));
      chk("w17_last", 32'(s_out_last), 32'(i == 8));
      chk("w17_ovf", 32'(s_ovf), 32'(expovf));
      step();
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    set_all(0);
    s_valid = 1'b0;
    s_last = 1'b0;
    s_out_ready = 1'b1;
    s_c = '0;
    for (int i = 0; i < 9; i++) m_acc[i] = 0;
    step();
    step();
    reset = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_term_cnt", 32'(term_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);

    // Single beat 1..9, consumer always ready.
    for (int i = 0; i < 9; i++) c[i] = IN_W'(i + 1);
    send(1'b1);
    drain(1'b0, cyc);
    chk("t1_drain_cycles", 32'(cyc), 32'd9);
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);
    chk("t1_term_cnt_clr", 32'(term_cnt), 32'd0);
    chk("t1_out_valid_low", 32'(out_valid), 32'd0);

    // Three outer products summed.
    set_outer(1, 2, 3, 4, 5, 6);
    send(1'b0);
    chk("t2_cnt_after1", 32'(term_cnt), 32'd1);
    set_outer(2, 2, 2, 1, 1, 1);
    send(1'b0);
    set_outer(0, 0, 1, 7, 0, 0);
    send(1'b1);
    drain(1'b0, cyc);

    // Stalled drain with upstream holding a beat; it is taken only after the drain.
    set_all(4);
    send(1'b1);
    set_all(2);
    in_valid = 1'b1;
    in_last = 1'b1;
    drain(1'b1, cyc);
    chk("t3_in_ready_back", 32'(in_ready), 32'd1);
    chk("t3_cnt_zero", 32'(term_cnt), 32'd0);
    model_add(1'b1);
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("t6_accepted", 32'(out_valid), 32'd1);
    drain(1'b0, cyc);

    // Abort mid-matrix with reset, then a fresh matrix of fives.
    set_all(3);
    send(1'b0);
    send(1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) m_acc[i] = 0;
    m_cnt = 0;
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    chk("t4_term_cnt", 32'(term_cnt), 32'd0);
    set_all(5);
    send(1'b1);
    drain(1'b0, cyc);

    // Narrow accumulators: no wrap with two beats, wrap and sticky ovf with three.
    s_c = IN_W'(65025);
    chk("w17_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    step();
    s_last = 1'b1;
    step();
    s_valid = 1'b0;
    s_last = 1'b0;
    drain17(130050, 1'b0);
    chk("w17_ready_back", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    step();
    step();
    s_last = 1'b1;
    step();
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("w17_cnt3", 32'(s_cnt), 32'd3);
    drain17(195075 - 131072, 1'b1);
    chk("w17_ovf_cleared", 32'(s_ovf), 32'd0);
    chk("w17_cnt_cleared", 32'(s_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
